// File: rtl/vga_scan_engine_if.sv
// Image-memory read port of the VGA scan engine.
//   addr_imgmem : framebuffer read address, driven by the scan engine
//   q_imgmem    : pixel {B,G,R} returned by the memory RD_LAT clocks later
// master = scan engine side, slave = image memory side.
interface vga_scan_engine_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] addr_imgmem;
    logic [23:0]       q_imgmem;

    modport master (output addr_imgmem, input  q_imgmem);
    modport slave  (input  addr_imgmem, output q_imgmem);
endinterface

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: parametrised VGA timing generator and framebuffer address
// sequencer. Sync/blank/region flags are pipelined so that they line up with
// the image-memory read data; every visible output appears RD_LAT+1 clocks
// after the scan position that produced it.
//
// Ports:
//   iVGA_CLK   pixel clock (rising edge)
//   iRST       synchronous active-high reset
//   mem        image-memory read port (addr_imgmem out, q_imgmem in)
//   iTEST      colour-bar test pattern select
//   oHS / oVS  sync outputs, active level HS_POL / VS_POL
//   oBLANK_n   high during visible pixels
//   b/g/r_data pixel colour, 0 while blanked
//   oFRAME     one-clock pulse at hcnt = 0, vcnt = V_ACTIVE (undelayed)
//
// Optional feature: define VGA_SCAN_TESTPATTERN_EN to build the colour-bar
// generator. Without it iTEST is ignored and no bar logic exists.
module vga_scan_engine #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          HS_POL      = 0,
    parameter int          VS_POL      = 0,
    parameter int          SCALE_SHIFT = 0,
    parameter int          FB_W        = 640,
    parameter int          FB_H        = 480,
    parameter int          ADDR_W      = 20,
    parameter int          RD_LAT      = 1,
    parameter logic [23:0] BORDER_BGR  = 24'h000000
) (
    input  logic                     iVGA_CLK,
    input  logic                     iRST,
    vga_scan_engine_if.master        mem,
    input  logic                     iTEST,
    output logic                     oHS,
    output logic                     oVS,
    output logic                     oBLANK_n,
    output logic [7:0]               b_data,
    output logic [7:0]               g_data,
    output logic [7:0]               r_data,
    output logic                     oFRAME
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare bit so the clamped framebuffer limits below always fit.
    localparam int HW = $clog2(H_TOTAL) + 1;
    localparam int VW = $clog2(V_TOTAL) + 1;
    localparam int SW = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] SUB_LAST = SW'((1 << SCALE_SHIFT) - 1);
    // A framebuffer wider/taller than the scan never clips.
    localparam logic [HW-1:0] FBW_L    = HW'((FB_W < H_TOTAL) ? FB_W : H_TOTAL);
    localparam logic [VW-1:0] FBH_L    = VW'((FB_H < V_TOTAL) ? FB_H : V_TOTAL);
    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);
    localparam logic HS_ACT = 1'(HS_POL);
    localparam logic VS_ACT = 1'(VS_POL);

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
        logic inreg;
`ifdef VGA_SCAN_TESTPATTERN_EN
        logic [2:0] bar;
`endif
    } flags_t;

    // Stage-0 scan state
    logic [HW-1:0]     hcnt, hcnt_n;
    logic [VW-1:0]     vcnt, vcnt_n;
    logic [SW-1:0]     hsub, hsub_n, vsub, vsub_n;
    logic [HW-1:0]     fx, fx_n;
    logic [VW-1:0]     fy, fy_n;
    logic [ADDR_W-1:0] row_base, row_base_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              frame_q;
    logic              h_wrap, v_wrap, in_region_n;

    flags_t            flags_s0;
    flags_t            dl [RD_LAT];
    flags_t            flags_d;

    logic              hs_q, vs_q, blank_n_q;
    logic [23:0]       rgb_q, pix_n;

    // Next scan position and the address that goes with it. Everything
    // is derived from the next position so addr_imgmem is registered
    // together with the counters and never shows an intermediate value.
    always_comb begin
        h_wrap     = (hcnt == H_LAST);
        v_wrap     = (vcnt == V_LAST);
        hcnt_n     = hcnt + HW'(1);
        hsub_n     = hsub + SW'(1);
        fx_n       = fx;
        vcnt_n     = vcnt;
        vsub_n     = vsub;
        fy_n       = fy;
        row_base_n = row_base;
        if (hsub == SUB_LAST) begin
            hsub_n = '0;
            fx_n   = fx + HW'(1);
        end
        if (h_wrap) begin
            hcnt_n = '0;
            hsub_n = '0;
            fx_n   = '0;
            vcnt_n = vcnt + VW'(1);
            vsub_n = vsub + SW'(1);
            if (vsub == SUB_LAST) begin
                vsub_n     = '0;
                fy_n       = fy + VW'(1);
                row_base_n = row_base + FB_W_A;
            end
            if (v_wrap) begin
                vcnt_n     = '0;
                vsub_n     = '0;
                fy_n       = '0;
                row_base_n = '0;
            end
        end
        in_region_n = (hcnt_n < H_ACT_L) && (vcnt_n < V_ACT_L) &&
                      (fx_n < FBW_L) && (fy_n < FBH_L);
        if (in_region_n)
            addr_n = row_base_n + ADDR_W'(fx_n);
        else if (vcnt_n >= V_ACT_L)
            addr_n = '0;
        else
            addr_n = addr_q;
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            hcnt     <= '0;
            vcnt     <= '0;
            hsub     <= '0;
            vsub     <= '0;
            fx       <= '0;
            fy       <= '0;
            row_base <= '0;
            addr_q   <= '0;
            frame_q  <= 1'b0;
        end else begin
            hcnt     <= hcnt_n;
            vcnt     <= vcnt_n;
            hsub     <= hsub_n;
            vsub     <= vsub_n;
            fx       <= fx_n;
            fy       <= fy_n;
            row_base <= row_base_n;
            addr_q   <= addr_n;
            frame_q  <= (hcnt_n == '0) && (vcnt_n == V_ACT_L);
        end
    end

    assign mem.addr_imgmem = addr_q;
    assign oFRAME          = frame_q;

    // Flags describing the current (stage-0) position.
    always_comb begin
        flags_s0       = '0;
        flags_s0.hs    = (hcnt >= HS_START) && (hcnt < HS_END);
        flags_s0.vs    = (vcnt >= VS_START) && (vcnt < VS_END);
        flags_s0.vis   = (hcnt < H_ACT_L) && (vcnt < V_ACT_L);
        flags_s0.inreg = flags_s0.vis && (fx < FBW_L) && (fy < FBH_L);
`ifdef VGA_SCAN_TESTPATTERN_EN
        // bar = floor(hcnt*8/H_ACTIVE) as a ladder of constant thresholds.
        for (int i = 1; i < 8; i++) begin
            if (32'(hcnt) * 8 >= i * H_ACTIVE)
                flags_s0.bar = 3'(i);
        end
`endif
    end

    // RD_LAT-deep delay line; cleared entries read as blanked, sync inactive.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            for (int i = 0; i < RD_LAT; i++)
                dl[i] <= '0;
        end else begin
            dl[0] <= flags_s0;
            for (int i = 1; i < RD_LAT; i++)
                dl[i] <= dl[i-1];
        end
    end

    assign flags_d = dl[RD_LAT-1];

    always_comb begin
        pix_n = '0;
        if (flags_d.vis) begin
            if (flags_d.inreg)
                pix_n = mem.q_imgmem;
            else
                pix_n = BORDER_BGR;
`ifdef VGA_SCAN_TESTPATTERN_EN
            if (iTEST)
                pix_n = {{8{flags_d.bar[2]}}, {8{flags_d.bar[1]}}, {8{flags_d.bar[0]}}};
`endif
        end
    end

`ifndef VGA_SCAN_TESTPATTERN_EN
    logic unused_test;
    assign unused_test = iTEST;
`endif

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            hs_q      <= ~HS_ACT;
            vs_q      <= ~VS_ACT;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            hs_q      <= flags_d.hs ? HS_ACT : ~HS_ACT;
            vs_q      <= flags_d.vs ? VS_ACT : ~VS_ACT;
            blank_n_q <= flags_d.vis;
            rgb_q     <= pix_n;
        end
    end

    assign oHS      = hs_q;
    assign oVS      = vs_q;
    assign oBLANK_n = blank_n_q;
    assign b_data   = rgb_q[23:16];
    assign g_data   = rgb_q[15:8];
    assign r_data   = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_engine.sv
module tb_vga_scan_engine;

    localparam int HA = 8, HT = 14, VA = 4, VT = 7, S = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic itest = 1'b0;

    always #5 clk = ~clk;

    vga_scan_engine_if #(.ADDR_W(20)) bus_a ();
    vga_scan_engine_if #(.ADDR_W(20)) bus_b ();

    logic       hs_a, vs_a, bl_a, fr_a, hs_b, vs_b, bl_b, fr_b;
    logic [7:0] b_a, g_a, r_a, b_b, g_b, r_b;

    vga_scan_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .SCALE_SHIFT(1), .FB_W(4), .FB_H(2),
        .ADDR_W(20), .RD_LAT(1), .BORDER_BGR(24'h000000)
    ) dut_a (
        .iVGA_CLK(clk), .iRST(rst), .mem(bus_a), .iTEST(itest),
        .oHS(hs_a), .oVS(vs_a), .oBLANK_n(bl_a),
        .b_data(b_a), .g_data(g_a), .r_data(r_a), .oFRAME(fr_a)
    );

    vga_scan_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .SCALE_SHIFT(1), .FB_W(3), .FB_H(1),
        .ADDR_W(20), .RD_LAT(1), .BORDER_BGR(24'h123456)
    ) dut_b (
        .iVGA_CLK(clk), .iRST(rst), .mem(bus_b), .iTEST(itest),
        .oHS(hs_b), .oVS(vs_b), .oBLANK_n(bl_b),
        .b_data(b_b), .g_data(g_b), .r_data(r_b), .oFRAME(fr_b)
    );

    // Image memories, 1-clock read latency.
    logic [23:0] mem_b [4];
    always @(posedge clk) bus_a.q_imgmem <= {bus_a.addr_imgmem, 4'h0};
    always @(posedge clk) bus_b.q_imgmem <= mem_b[bus_b.addr_imgmem[1:0]];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: mt = clocks since the last reset edge.
    int          mt = 0;
    logic [19:0] last_a = '0, last_b = '0;
    logic        tst_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, mt);
        end
    endtask

    function automatic logic [19:0] addr_rule(input int tt, input int fbw, input int fbh,
                                              input logic [19:0] prev);
        int h = tt % HT;
        int v = (tt / HT) % VT;
        int fx = h >> S;
        int fy = v >> S;
        if (h < HA && v < VA && fx < fbw && fy < fbh) return 20'(fy * fbw + fx);
        if (v >= VA) return '0;
        return prev;
    endfunction

    function automatic logic [23:0] pix_rule(input int tt, input int fbw, input int fbh,
                                             input logic [23:0] border, input logic tst,
                                             input bit is_a);
        int p, h, v, fx, fy;
        logic [19:0] a;
        logic [2:0]  bar;
        if (tt < 2) return '0;
        p = tt - 2;
        h = p % HT;
        v = (p / HT) % VT;
        fx = h >> S;
        fy = v >> S;
        if (!(h < HA && v < VA)) return '0;
`ifdef VGA_SCAN_TESTPATTERN_EN
        if (tst) begin
            bar = 3'(h * 8 / HA);
            return {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
        end
`else
        bar = {3{tst}};
`endif
        if (fx < fbw && fy < fbh) begin
            a = 20'(fy * fbw + fx);
            return is_a ? {a, 4'h0} : mem_b[a[1:0]];
        end
        return border;
    endfunction

    function automatic logic hs_rule(input int tt);
        int h;
        if (tt < 2) return 1'b1;
        h = (tt - 2) % HT;
        return !(h >= 10 && h < 12);
    endfunction

    function automatic logic vs_rule(input int tt);
        int v;
        if (tt < 2) return 1'b1;
        v = ((tt - 2) / HT) % VT;
        return !(v == 5);
    endfunction

    function automatic logic blank_rule(input int tt);
        int p;
        if (tt < 2) return 1'b0;
        p = tt - 2;
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction

    task automatic check_model();
        logic fr;
        fr = ((mt % HT) == 0) && (((mt / HT) % VT) == VA);
        chk("addr_a",  bus_a.addr_imgmem, last_a);
        chk("addr_b",  bus_b.addr_imgmem, last_b);
        chk("hs_a",    hs_a, hs_rule(mt));
        chk("vs_a",    vs_a, vs_rule(mt));
        chk("blank_a", bl_a, blank_rule(mt));
        chk("frame_a", fr_a, fr);
        chk("rgb_a",   {b_a, g_a, r_a}, pix_rule(mt, 4, 2, 24'h000000, tst_m, 1'b1));
        chk("hs_b",    hs_b, hs_rule(mt));
        chk("vs_b",    vs_b, vs_rule(mt));
        chk("blank_b", bl_b, blank_rule(mt));
        chk("frame_b", fr_b, fr);
        chk("rgb_b",   {b_b, g_b, r_b}, pix_rule(mt, 3, 1, 24'h123456, tst_m, 1'b0));
    endtask

    task automatic step(input logic r, input logic t_in);
        rst   = r;
        itest = t_in;
        @(posedge clk);
        if (r) begin
            mt = 0;
            last_a = '0;
            last_b = '0;
        end else begin
            mt++;
            last_a = addr_rule(mt, 4, 2, last_a);
            last_b = addr_rule(mt, 3, 1, last_b);
        end
        tst_m = t_in;
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        int          t;
        logic [19:0] addr_a, addr_b;
        logic        hs, vs, blank, frame;
        logic [23:0] rgb_a, rgb_b;
        bit          chk_b;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int   n;
        int   rlen;
        logic tst_cur;
        logic [23:0] bars [8];

        for (int i = 0; i < 4; i++) mem_b[i] = 24'($urandom);

        //        t    addr_a addr_b hs vs bl fr  rgb_a        rgb_b        chk_b
        vecs[0]  = '{0,   0, 0, 1, 1, 0, 0, 24'h000000, 24'h000000, 1};
        vecs[1]  = '{2,   1, 1, 1, 1, 1, 0, 24'h000000, 24'h000000, 0};
        vecs[2]  = '{4,   2, 2, 1, 1, 1, 0, 24'h000010, 24'h000000, 0};
        vecs[3]  = '{6,   3, 2, 1, 1, 1, 0, 24'h000020, 24'h000000, 0};
        vecs[4]  = '{8,   3, 2, 1, 1, 1, 0, 24'h000030, 24'h123456, 1};
        vecs[5]  = '{9,   3, 2, 1, 1, 1, 0, 24'h000030, 24'h123456, 1};
        vecs[6]  = '{10,  3, 2, 1, 1, 0, 0, 24'h000000, 24'h000000, 1};
        vecs[7]  = '{12,  3, 2, 0, 1, 0, 0, 24'h000000, 24'h000000, 1};
        vecs[8]  = '{13,  3, 2, 0, 1, 0, 0, 24'h000000, 24'h000000, 1};
        vecs[9]  = '{14,  0, 0, 1, 1, 0, 0, 24'h000000, 24'h000000, 1};
        vecs[10] = '{29,  4, 2, 1, 1, 0, 0, 24'h000000, 24'h000000, 1};
        vecs[11] = '{33,  6, 2, 1, 1, 1, 0, 24'h000050, 24'h123456, 1};
        vecs[12] = '{56,  0, 0, 1, 1, 0, 1, 24'h000000, 24'h000000, 1};
        vecs[13] = '{57,  0, 0, 1, 1, 0, 0, 24'h000000, 24'h000000, 1};
        vecs[14] = '{72,  0, 0, 1, 0, 0, 0, 24'h000000, 24'h000000, 1};
        vecs[15] = '{86,  0, 0, 1, 1, 0, 0, 24'h000000, 24'h000000, 1};
        vecs[16] = '{98,  0, 0, 1, 1, 0, 0, 24'h000000, 24'h000000, 1};
        vecs[17] = '{100, 1, 1, 1, 1, 1, 0, 24'h000000, 24'h000000, 0};

        bars = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                 24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

        // Directed table run from a clean reset.
        step(1, 0);
        step(1, 0);
        for (int c = 0; c <= 110; c++) begin
            if (c > 0) step(0, 0);
            foreach (vecs[k]) begin
                if (vecs[k].t == mt) begin
                    chk("tbl_addr_a", bus_a.addr_imgmem, vecs[k].addr_a);
                    chk("tbl_addr_b", bus_b.addr_imgmem, vecs[k].addr_b);
                    chk("tbl_hs",     hs_a, vecs[k].hs);
                    chk("tbl_vs",     vs_a, vecs[k].vs);
                    chk("tbl_blank",  bl_a, vecs[k].blank);
                    chk("tbl_frame",  fr_a, vecs[k].frame);
                    chk("tbl_rgb_a",  {b_a, g_a, r_a}, vecs[k].rgb_a);
                    if (vecs[k].chk_b)
                        chk("tbl_rgb_b", {b_b, g_b, r_b}, vecs[k].rgb_b);
                end
            end
        end

        // Mid-frame reset at hcnt = 5, vcnt = 2.
        step(1, 0);
        while (mt < 33) step(0, 0);
        step(1, 0);
        chk("mid_rst_blank", bl_a, 1'b0);
        chk("mid_rst_hs",    hs_a, 1'b1);
        chk("mid_rst_vs",    vs_a, 1'b1);
        chk("mid_rst_addr",  bus_a.addr_imgmem, 20'd0);
        chk("mid_rst_rgb",   {b_a, g_a, r_a}, 24'h000000);
        n = 0;
        while (fr_a !== 1'b1 && n < 200) begin
            step(0, 0);
            n++;
        end
        chk("frame_after_release", n, 56);

`ifdef VGA_SCAN_TESTPATTERN_EN
        // Colour bars on line 0, then memory data again on line 1.
        step(1, 1);
        while (mt < 9) begin
            step(0, 1);
            if (mt >= 2) begin
                chk("bar_a", {b_a, g_a, r_a}, bars[mt-2]);
                chk("bar_b", {b_b, g_b, r_b}, bars[mt-2]);
            end
        end
        while (mt < 18) step(0, 0);
        chk("bar_off_a", {b_a, g_a, r_a}, 24'h000010);
`else
        bars[0] = 24'h000000;
`endif

        // Randomized run: random resets and iTEST changes against the model.
        tst_cur = 1'b0;
        rlen = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) tst_cur = ~tst_cur;
            if (rlen == 0 && $urandom_range(0, 299) == 0) rlen = $urandom_range(1, 3);
            if (rlen > 0) begin
                step(1, tst_cur);
                rlen--;
            end else begin
                step(0, tst_cur);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_scan_engine.md
# vga_scan_engine

Parametrised VGA scan engine that generates sync and blanking timing and framebuffer read addresses, and realigns returned pixel data to the delayed sync outputs. It replaces the fixed 640x480 controller. Resolution, porches and sync polarity are parameters, the framebuffer may be smaller than the screen (integer pixel replication plus a border colour), and memory read latency is configurable. It sits between the pixel-clock domain image memory (game renderer output) and the VGA DAC pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches / sync in lines
- HS_POL / VS_POL, 0 / 0, active level of oHS / oVS (0 = active-low)
- SCALE_SHIFT, 0, each framebuffer pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels
- FB_W / FB_H, 640 / 480, framebuffer size in framebuffer pixels
- ADDR_W, 20, address width; must satisfy 2^ADDR_W >= FB_W*FB_H
- RD_LAT, 1, image-memory read latency in clocks, >= 1
- BORDER_BGR, 24'h000000, colour outside the framebuffer region

Ports:
- iVGA_CLK  in  1  pixel clock, all logic on rising edge
- iRST  in  1  synchronous, active-high reset
- addr_imgmem  out  ADDR_W  framebuffer read address for current scan position
- q_imgmem  in  24  pixel {B,G,R}, valid RD_LAT clocks after its address
- iTEST  in  1  test-pattern select (see Configuration)
- oHS / oVS  out  1  sync outputs, polarity per HS_POL / VS_POL
- oBLANK_n  out  1  high during visible pixels
- b_data / g_data / r_data  out  8  pixel colour, 0 while blanked
- oFRAME  out  1  one-clock pulse at start of vertical blanking (undelayed)

## Operation
- hcnt counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. It wraps to 0 and then advances vcnt, which counts 0..V_TOTAL-1 and wraps to 0.
- Region order per axis: active, then front porch, then sync, then back porch. Horizontal sync is active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Vertical sync is active for whole lines with vcnt in the same relative span.
- Visible = hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- Framebuffer coordinates: fx = hcnt>>SCALE_SHIFT, fy = vcnt>>SCALE_SHIFT. A pixel is in the region when visible, fx < FB_W and fy < FB_H.
- addr_imgmem = fy*FB_W + fx while in region. It is generated incrementally with a row base register, a column counter and replication sub-counters; no multiplier.
- Outside the region, addr_imgmem holds its last value. It is 0 for the whole vertical blanking interval.
- Pixel output is chosen per delayed position:
  - blanked: 0
  - visible and in region: q_imgmem
  - visible and outside region: BORDER_BGR
- b_data = [23:16], g_data = [15:8], r_data = [7:0].
- oFRAME is high for exactly the one clock where hcnt = 0 and vcnt = V_ACTIVE.

## Timing
- Stage 0: counters and addr_imgmem for position P.
- oHS, oVS, oBLANK_n and pixel data for P appear registered exactly RD_LAT+1 clocks later. The sync, blank and region flags travel through an RD_LAT-deep delay line, so they stay aligned with q_imgmem.
- Reset (iRST high at a rising edge), including mid-frame:
  - hcnt = vcnt = 0, addr_imgmem = 0
  - delay line cleared to the blanked state
  - oHS = ~HS_POL, oVS = ~VS_POL, oBLANK_n = 0, rgb = 0, oFRAME = 0
- After iRST deasserts, scanning starts at P = (0,0) on the next clock. The first visible pixel reaches the outputs RD_LAT+1 clocks later.
- Wrap events:
  - End of line (hcnt wraps) and end of frame (vcnt wraps) happen on the same edge. addr_imgmem returns to 0 on that edge, with no glitch value.
  - The replication sub-counters reset at every line and frame start.
- q_imgmem is sampled on every clock and ignored when not visible or outside the region.

## Configuration
- VGA_SCAN_TESTPATTERN_EN defined:
  - When iTEST = 1, visible pixels show 8 vertical colour bars: bar index = hcnt*8/H_ACTIVE, bit0→R, bit1→G, bit2→B, each 8'hFF or 0.
  - q_imgmem and the border colour are ignored; timing and latency are unchanged.
- Macro undefined: iTEST is present but ignored, and no bar logic is synthesised.

## Test plan
Small-screen parameters for all scenarios: H 8/2/2/2, V 4/1/1/1, SCALE_SHIFT = 1, FB_W = 4, FB_H = 2, RD_LAT = 1. This gives H_TOTAL = 14 and a frame of 98 clocks.

- Address sequence: release reset and record addr_imgmem on line 0 → 0,0,1,1,2,2,3,3. Line 1 repeats it. Lines 2 and 3 → 4,4,5,5,6,6,7,7. Vertical blank → 0.
- Sync and blank timing: oHS low exactly 2 clocks, starting at clock index 12 of each line (hcnt 10 plus 2 latency). oBLANK_n high 8 clocks per active line, 4 lines per frame. oVS low 1 line. Frame period is 98 clocks.
- Data alignment: memory model returns q = {addr, 4'h0} with 1-clock latency. The pixel at output visible index k carries address k>>1.
- Border: set FB_W = 3 → x = 6,7 output BORDER_BGR = 24'h123456 and addr_imgmem holds at 2. Set FB_H = 1 → lines 2 and 3 are all border.
- Reset mid-frame: assert iRST at hcnt = 5, vcnt = 2 → next edge gives blank outputs, oHS and oVS inactive, addr 0. After release, the pattern restarts at (0,0). oFRAME pulses first 56 clocks after release.
- Test pattern (macro on, iTEST = 1) → bars R,G,B per hcnt 0..7 = 000,001,010,011,100,101,110,111 in BGR bit order. With iTEST = 0 the output equals the memory data.
